// File: rtl/gen_pipe_reg.sv
// Elastic valid/ready register chain: DEPTH stages, bubble collapsing,
// synchronous flush and a registered occupancy count.
module gen_pipe_stage #(
  parameter int                    DATA_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  flush_in,
  input  logic                  adv,
  input  logic                  up_vld,
  input  logic [DATA_WIDTH-1:0] up_data,
  output logic                  vld,
  output logic [DATA_WIDTH-1:0] data
);
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      vld  <= 1'b0;
      data <= RESET_VALUE;
    end else if (flush_in) begin
      vld  <= 1'b0;
    end else if (adv) begin
      vld <= up_vld;
      // Bubbles leave the data register untouched
      if (up_vld) data <= up_data;
    end
  end
endmodule

module gen_pipe_reg #(
  parameter int                    DATA_WIDTH  = 4,
  parameter int                    DEPTH       = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  localparam int                   OCC_W       = $clog2(DEPTH+1)
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  flush_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [OCC_W-1:0]      occupancy_out
);
  logic [DEPTH-1:0]                 vld_pipe;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_pipe;
  logic [DEPTH-1:0]                 adv;
  logic [DEPTH-1:0]                 up_vld;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] up_data;
  logic                             accept, emit;
  logic [OCC_W-1:0]                 occ_q;

  // Advance resolves from the output end back toward the input
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = !vld_pipe[DEPTH-1] || ready_in;
    for (int i = DEPTH-2; i >= 0; i--) adv[i] = !vld_pipe[i] || adv[i+1];
  end

  always_comb begin
    up_vld     = '0;
    up_data    = '0;
    up_vld[0]  = valid_in;
    up_data[0] = data_in;
    for (int i = 1; i < DEPTH; i++) begin
      up_vld[i]  = vld_pipe[i-1];
      up_data[i] = data_pipe[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    gen_pipe_stage #(.DATA_WIDTH(DATA_WIDTH), .RESET_VALUE(RESET_VALUE)) u_stage (
      .clock_in (clock_in),
      .reset_in (reset_in),
      .flush_in (flush_in),
      .adv      (adv[g]),
      .up_vld   (up_vld[g]),
      .up_data  (up_data[g]),
      .vld      (vld_pipe[g]),
      .data     (data_pipe[g])
    );
  end

  assign ready_out = adv[0] && !flush_in;
  assign valid_out = vld_pipe[DEPTH-1];
  assign data_out  = data_pipe[DEPTH-1];
  assign accept    = valid_in && ready_out;
  assign emit      = valid_out && ready_in;

  always_ff @(posedge clock_in) begin
    if (reset_in || flush_in) occ_q <= '0;
    else if (accept && !emit) occ_q <= occ_q + 1'b1;
    else if (emit && !accept) occ_q <= occ_q - 1'b1;
  end

  assign occupancy_out = occ_q;
endmodule

// File: tb/tb_gen_pipe_reg.sv
// Scoreboard bench for gen_pipe_reg: DEPTH=2, DATA_WIDTH=8.
module tb_gen_pipe_reg;
  localparam int DW = 8;
  localparam int DP = 2;

  logic          clock_in, reset_in, flush_in, valid_in, ready_in;
  logic          ready_out, valid_out;
  logic [DW-1:0] data_in, data_out;
  logic [1:0]    occupancy_out;

  logic [DW-1:0] q[$];
  int            nvec, nerr;
  logic          acc;

  gen_pipe_reg #(.DATA_WIDTH(DW), .DEPTH(DP), .RESET_VALUE(8'h00)) dut (
    .clock_in      (clock_in),
    .reset_in      (reset_in),
    .flush_in      (flush_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .data_in       (data_in),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .data_out      (data_out),
    .occupancy_out (occupancy_out)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle; scoreboard work happens mid-cycle, away from the edge.
  task automatic step(input logic vin, input logic [DW-1:0] din, input logic rin,
                      input logic fl, input logic rs, output logic accepted);
    logic [DW-1:0] e;
    valid_in = vin; data_in = din; ready_in = rin; flush_in = fl; reset_in = rs;
    #4;
    accepted = 1'b0;
    if (rs) q.delete();
    else begin
      chk("occ", occupancy_out, q.size());
      if (valid_out && ready_in) begin
        if (q.size() == 0) chk("unexp_emit", valid_out, 1'b0);
        else begin
          e = q.pop_front();
          chk("data", data_out, e);
        end
      end
      if (fl) begin
        chk("flush_rdy", ready_out, 1'b0);
        q.delete();
      end else if (valid_in && ready_out) begin
        q.push_back(din);
        accepted = 1'b1;
      end
    end
    @(posedge clock_in); #1;
  endtask

  task automatic send(input logic [DW-1:0] w, input logic rin);
    logic a;
    int   n;
    a = 1'b0; n = 0;
    while (!a && n < 20) begin
      step(1'b1, w, rin, 1'b0, 1'b0, a);
      n++;
    end
    chk("send_timeout", a, 1'b1);
  endtask

  task automatic drain();
    logic a;
    int   n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      step(1'b0, '0, 1'b1, 1'b0, 1'b0, a);
      n++;
    end
    chk("drain", q.size(), 0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, a);
  endtask

  initial begin
    nvec = 0; nerr = 0;
    valid_in = 0; data_in = '0; ready_in = 0; flush_in = 0; reset_in = 1;

    // Reset held two cycles
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
    reset_in = 0; ready_in = 1; #1;
    chk("rst_vld", valid_out, 1'b0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_occ", occupancy_out, 0);
    chk("rst_rdy", ready_out, 1'b1);

    // Streaming: latency of DEPTH cycles, back-to-back output
    step(1'b1, 8'h11, 1'b1, 1'b0, 1'b0, acc);
    chk("lat_vld0", valid_out, 1'b0);
    step(1'b1, 8'h22, 1'b1, 1'b0, 1'b0, acc);
    chk("lat_vld1", valid_out, 1'b1);
    chk("lat_data", data_out, 8'h11);
    chk("peak_occ", occupancy_out, 2);
    step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, acc);
    chk("stream_vld", valid_out, 1'b1);
    chk("stream_data", data_out, 8'h22);
    drain();

    // Back-pressure: third word held by producer until ready returns
    step(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, acc);
    chk("a1_acc", acc, 1'b1);
    step(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, acc);
    chk("a2_acc", acc, 1'b1);
    step(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0, acc);
    chk("a3_held", acc, 1'b0);
    chk("bp_occ", occupancy_out, 2);
    send(8'hA3, 1'b1);
    drain();

    // Full pipe with simultaneous accept and emit
    step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 8'h6B, 1'b0, 1'b0, 1'b0, acc);
    chk("full_rdy", ready_out, 1'b0);
    chk("full_data", data_out, 8'h5A);
    step(1'b1, 8'h7C, 1'b1, 1'b0, 1'b0, acc);
    chk("thru_acc", acc, 1'b1);
    chk("thru_occ", occupancy_out, 2);
    chk("thru_next", data_out, 8'h6B);

    // Flush of full pipe; 0xEE refused, data register left intact
    step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, acc);
    chk("fl_vld", valid_out, 1'b0);
    chk("fl_occ", occupancy_out, 0);
    chk("fl_data", data_out, 8'h6B);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);

    // Mid-stream reset together with flush
    step(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, acc);
    step(1'b1, 8'h02, 1'b1, 1'b0, 1'b0, acc);
    step(1'b1, 8'h03, 1'b1, 1'b1, 1'b1, acc);
    valid_in = 0; flush_in = 0; reset_in = 0; ready_in = 1; #1;
    chk("mrst_vld", valid_out, 1'b0);
    chk("mrst_data", data_out, 8'h00);
    chk("mrst_occ", occupancy_out, 0);
    chk("mrst_rdy", ready_out, 1'b1);
    step(1'b1, 8'h99, 1'b1, 1'b0, 1'b0, acc);
    chk("p99_vld0", valid_out, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, acc);
    chk("p99_vld1", valid_out, 1'b1);
    chk("p99_data", data_out, 8'h99);
    drain();

    // Random traffic with occasional flushes
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 40) == 0), 1'b0, acc);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
